// File: rtl/fault_blinker_pkg.sv
// Shared types and sizing helpers for the fault-code LED blinker.
package fault_blinker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_GAP  = 2'd3
    } state_e;

    // Bits needed to hold any value in 0..max_val (never less than 1).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/fault_blinker_tick_prescaler.sv
// Free-running tick divider with synchronous clear; tick pulses on the last count.
module tick_prescaler
    import fault_blinker_pkg::*;
#(
    parameter int unsigned TICK_DIV = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = cnt_width(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;

    assign tick = (cnt_q == CW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/fault_blinker.sv
// Status LED driver: mirrors the heartbeat, or blinks a latched fault code as N pulses plus a gap.
module fault_blinker
    import fault_blinker_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 250000,
    parameter int unsigned ON_TICKS  = 20,
    parameter int unsigned OFF_TICKS = 30,
    parameter int unsigned GAP_TICKS = 150,
    parameter int unsigned CODE_W    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hb_in,
    input  logic [CODE_W-1:0] fault_code,
    output logic              led,
    output logic              busy,
    output logic              burst_done
);

    localparam int unsigned PW = cnt_width(max3(ON_TICKS, OFF_TICKS, GAP_TICKS) - 1);

    state_e            state_q;
    logic [PW-1:0]     phase_q;
    logic [CODE_W-1:0] rem_q;
    logic              led_q;

    logic              tick;
    logic              clr;
    logic              phase_end;
    logic [PW-1:0]     phase_last;

    always_comb begin
        phase_last = '0;
        case (state_q)
            ST_ON:   phase_last = PW'(ON_TICKS - 1);
            ST_OFF:  phase_last = PW'(OFF_TICKS - 1);
            ST_GAP:  phase_last = PW'(GAP_TICKS - 1);
            default: phase_last = '0;
        endcase
    end

    assign phase_end = (state_q != ST_IDLE) && tick && (phase_q == phase_last);
    // Holding the prescaler clear through IDLE makes the first ON phase full length.
    assign clr       = (state_q == ST_IDLE) || phase_end;

    tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clr),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            rem_q   <= '0;
            led_q   <= 1'b0;
        end else begin
            if (state_q == ST_IDLE || phase_end) begin
                phase_q <= '0;
            end else if (tick) begin
                phase_q <= phase_q + PW'(1);
            end

            case (state_q)
                ST_IDLE: begin
                    led_q <= hb_in;
                    if (fault_code != '0) begin
                        rem_q   <= fault_code;
                        state_q <= ST_ON;
                        led_q   <= 1'b1;
                    end
                end
                ST_ON: begin
                    if (phase_end) begin
                        rem_q   <= rem_q - CODE_W'(1);
                        state_q <= (rem_q == CODE_W'(1)) ? ST_GAP : ST_OFF;
                        led_q   <= 1'b0;
                    end
                end
                ST_OFF: begin
                    if (phase_end) begin
                        state_q <= ST_ON;
                        led_q   <= 1'b1;
                    end
                end
                ST_GAP: begin
                    // fault_code is only re-sampled here, so a running burst always completes.
                    if (phase_end) begin
                        if (fault_code != '0) begin
                            rem_q   <= fault_code;
                            state_q <= ST_ON;
                            led_q   <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                            led_q   <= hb_in;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    led_q   <= 1'b0;
                end
            endcase
        end
    end

    assign led        = led_q;
    assign busy       = (state_q != ST_IDLE);
    assign burst_done = (state_q == ST_GAP) && phase_end;

endmodule

// File: tb/tb_fault_blinker.sv
// Directed bench for fault_blinker with small timing parameters (8-cycle pulse, 4 off, 12 gap).
module tb_fault_blinker;

    logic       clk;
    logic       rst_n;
    logic       hb_in;
    logic [3:0] fault_code;
    logic       led;
    logic       busy;
    logic       burst_done;

    int nchecks = 0;
    int nerrors = 0;

    typedef struct {
        logic [3:0] fault;
        logic       hb;
        logic       exp_led;
        logic       exp_busy;
        logic       exp_done;
    } vec_t;

    vec_t tab [12];

    fault_blinker #(
        .TICK_DIV (4),
        .ON_TICKS (2),
        .OFF_TICKS(1),
        .GAP_TICKS(3),
        .CODE_W   (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hb_in     (hb_in),
        .fault_code(fault_code),
        .led       (led),
        .busy      (busy),
        .burst_done(burst_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    // Applies the idle table; the row's hb is launched now and seen on led after the next edge.
    task automatic run_idle();
        for (int unsigned k = 0; k < 12; k++) begin
            fault_code = tab[k].fault;
            hb_in      = tab[k].hb;
            @(negedge clk);
            chk("idle_led", led, tab[k].exp_led);
            chk("idle_busy", busy, tab[k].exp_busy);
            chk("idle_done", burst_done, tab[k].exp_done);
        end
    endtask

    // Checks one full burst of n pulses; the burst's ON entry happens at the next posedge.
    // At cycle index chg (after checking) fault_code is changed to nc.
    task automatic run_burst(input int n, input int chg, input logic [3:0] nc);
        int   len;
        logic el;
        len = 12 * n + 8;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            if (i < 12 * (n - 1)) el = ((i % 12) < 8);
            else                  el = ((i - 12 * (n - 1)) < 8);
            chk("burst_led", led, el);
            chk("burst_busy", busy, 1'b1);
            chk("burst_done", burst_done, (i == len - 1));
            if (i == chg) fault_code = nc;
        end
    endtask

    initial begin
        tab = '{
            '{4'd0, 1'b1, 1'b1, 1'b0, 1'b0},
            '{4'd0, 1'b0, 1'b0, 1'b0, 1'b0},
            '{4'd0, 1'b0, 1'b0, 1'b0, 1'b0},
            '{4'd0, 1'b1, 1'b1, 1'b0, 1'b0},
            '{4'd0, 1'b1, 1'b1, 1'b0, 1'b0},
            '{4'd0, 1'b1, 1'b1, 1'b0, 1'b0},
            '{4'd0, 1'b0, 1'b0, 1'b0, 1'b0},
            '{4'd0, 1'b1, 1'b1, 1'b0, 1'b0},
            '{4'd0, 1'b0, 1'b0, 1'b0, 1'b0},
            '{4'd0, 1'b1, 1'b1, 1'b0, 1'b0},
            '{4'd0, 1'b1, 1'b1, 1'b0, 1'b0},
            '{4'd0, 1'b0, 1'b0, 1'b0, 1'b0}
        };

        rst_n      = 1'b0;
        hb_in      = 1'b1;
        fault_code = 4'd0;
        #12;
        chk("rst_led", led, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", burst_done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        run_idle();

        fault_code = 4'd3;
        run_burst(3, -1, 4'd0);
        run_burst(3, 14, 4'd5);
        run_burst(5, 20, 4'd3);
        run_burst(3, 9, 4'd0);
        run_idle();

        fault_code = 4'd1;
        run_burst(1, 0, 4'd15);
        run_burst(15, 0, 4'd0);
        run_idle();

        fault_code = 4'd2;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("pre_rst_led", led, 1'b1);
        chk("pre_rst_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_led", led, 1'b0);
        chk("async_rst_busy", busy, 1'b0);
        chk("async_rst_done", burst_done, 1'b0);
        @(negedge clk);
        chk("held_rst_led", led, 1'b0);
        rst_n = 1'b1;
        run_burst(2, 0, 4'd0);
        run_idle();

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule

// File: doc/fault_blinker.md
Name: fault_blinker

Overview:
- Downstream consumer of the heartbeat LED signal. Drives the board status LED.
- With no fault present, the LED mirrors the heartbeat input.
- With a nonzero fault code present, the block takes over the LED and blinks the code: N pulses, then a long gap, repeating while the fault persists.
- Sits between the heartbeat generator and the LED pin. Fault codes come from the motion-engine supervisor.

Parameters:
- TICK_DIV, 250000: clocks per timing tick (10 ms at 25 MHz); minimum 2.
- ON_TICKS, 20: ticks the LED is on per pulse; minimum 1.
- OFF_TICKS, 30: ticks the LED is off between pulses; minimum 1.
- GAP_TICKS, 150: ticks the LED is off after the last pulse of a burst; minimum 1.
- CODE_W, 4: fault code width; maximum code is 2^CODE_W-1 pulses.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- hb_in  in  1  heartbeat level from the upstream blinker
- fault_code  in  CODE_W  0 = no fault; nonzero = number of pulses to blink
- led  out  1  registered LED drive
- busy  out  1  high while a burst is in progress (any state other than IDLE)
- burst_done  out  1  one-cycle pulse at the end of each GAP

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; led=0, busy=0, burst_done=0.
  - Prescaler, phase counter, remaining count and latched code all 0.
- Prescaler:
  - Counts 0..TICK_DIV-1 and emits tick when it reaches TICK_DIV-1.
  - Cleared to 0 on every phase entry (IDLE->ON, ON->OFF, OFF->ON, ON->GAP, GAP->ON).
  - Each phase therefore lasts exactly PHASE_TICKS*TICK_DIV clocks.
- Phase counter: counts ticks within the current phase and is cleared on phase entry.
- All counter widths are sized with $clog2 of their maximum value.
- IDLE:
  - led <= hb_in (one-cycle latency); busy=0.
  - On any clock where fault_code != 0: latch code_q=fault_code, remaining=fault_code, go to ON.
  - led=1 and busy=1 from the next cycle.
- ON:
  - led=1.
  - After ON_TICKS ticks, remaining decrements.
  - If remaining was 1, go to GAP; otherwise go to OFF.
- OFF: led=0; after OFF_TICKS ticks, go to ON.
- GAP:
  - led=0; after GAP_TICKS ticks, burst_done=1 for one cycle.
  - In the same cycle fault_code is sampled: nonzero latches it and goes to ON; zero goes to IDLE.
- fault_code changes during ON, OFF or GAP are ignored until the GAP exit sample. This includes a change to 0: the current burst always completes.
- hb_in is ignored whenever busy=1.
- Reset asserted mid-burst: led drops to 0 asynchronously; after release the block resumes in IDLE.

Decomposition:
- Shared package: state encoding (IDLE, ON, OFF, GAP) as localparams, plus the derived counter-width constants.
- One natural sub-module, tick_prescaler (parameter TICK_DIV):
  - Inputs clk, rst_n and a synchronous clr.
  - Output tick, a one-cycle pulse.
- All remaining logic (FSM, counters, output registers) stays in fault_blinker.

Test Plan (TICK_DIV=4, ON_TICKS=2, OFF_TICKS=1, GAP_TICKS=3, CODE_W=4):
- fault_code=0, hb_in toggled with a random pattern -> led equals hb_in delayed one cycle; busy=0; burst_done never pulses.
- fault_code=3 held -> busy rises the cycle after the code appears. led sequence: 8 high, 4 low, 8 high, 4 low, 8 high, 12 low. burst_done pulses on the last gap cycle, then the pattern repeats.
- fault_code=3, changed to 5 during the second pulse -> the current burst still has 3 pulses; the next burst has 5 pulses.
- fault_code=3, changed to 0 during OFF -> the burst completes its 3 pulses and the gap. The block then returns to IDLE, led tracks hb_in, and busy=0.
- fault_code=1 -> one 8-cycle pulse, 12 low. fault_code=15 -> 15 pulses; burst length 15*8 + 14*4 + 12 = 188 cycles.
- rst_n driven low mid-ON, asynchronously to clk -> led=0, busy=0 without waiting for a clock edge. After release with fault_code=2, a fresh 2-pulse burst starts from IDLE.
